// File: rtl/instruction_fetch_stage.sv
// IF pipeline stage: owns the PC, drives the instruction memory address and
// captures the fetched word into the IF/ID register with stall and branch flush.
module instruction_fetch_stage #(
  parameter int          MEM_BYTES = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_instruction,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  // Keeps addresses inside the memory window and word-aligned in one AND.
  localparam logic [31:0] PC_MASK = 32'(MEM_BYTES - 1) & 32'hFFFF_FFFC;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;

  assign pc_plus4      = (pc + 32'd4) & PC_MASK;
  assign branch_target = branch_address & PC_MASK;
  assign mem_address   = pc;

  // Branch beats freeze; mem_instruction is only looked at on advance edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc                <= RESET_PC & PC_MASK;
      if_id_pc          <= 32'd0;
      if_id_instruction <= 32'd0;
      if_id_valid       <= 1'b0;
      fetch_count       <= 32'd0;
    end else if (branch_taken) begin
      pc                <= branch_target;
      if_id_pc          <= 32'd0;
      if_id_instruction <= 32'd0;
      if_id_valid       <= 1'b0;
    end else if (!freeze) begin
      pc                <= pc_plus4;
      if_id_pc          <= pc_plus4;
      if_id_instruction <= mem_instruction;
      if_id_valid       <= 1'b1;
      fetch_count       <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: free-run, freeze, branch flush,
// address wrap, asynchronous reset and X isolation on the memory data bus.
module tb_instruction_fetch_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [31:0] mem_address;
  logic [31:0] mem_instruction;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic [31:0] fetch_count;
  logic        force_x;

  int n_cmp;
  int n_fail;

  instruction_fetch_stage #(.MEM_BYTES(256), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .freeze           (freeze),
    .branch_taken     (branch_taken),
    .branch_address   (branch_address),
    .mem_address      (mem_address),
    .mem_instruction  (mem_instruction),
    .if_id_pc         (if_id_pc),
    .if_id_instruction(if_id_instruction),
    .if_id_valid      (if_id_valid),
    .fetch_count      (fetch_count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: two real opcodes at 0 and 4, a recognisable tag elsewhere.
  always_comb begin
    if (force_x)                     mem_instruction = 32'hxxxx_xxxx;
    else if (mem_address == 32'h0)   mem_instruction = 32'hE3A0_0014;
    else if (mem_address == 32'h4)   mem_instruction = 32'hE3A0_1A01;
    else                             mem_instruction = 32'hC0DE_0000 | mem_address;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                           input logic [31:0] ipc, input logic vld, input logic [31:0] cnt);
    check({tag, ".mem_address"}, mem_address, addr);
    check({tag, ".if_id_instruction"}, if_id_instruction, instr);
    check({tag, ".if_id_pc"}, if_id_pc, ipc);
    check({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, vld});
    check({tag, ".fetch_count"}, fetch_count, cnt);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_address = 32'h0;
    force_x = 1'b0;

    step();
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    rst = 1'b0;

    // Free-run from reset
    step();
    check_all("run1", 32'h4, 32'hE3A0_0014, 32'h4, 1'b1, 32'd1);
    step();
    check_all("run2", 32'h8, 32'hE3A0_1A01, 32'h8, 1'b1, 32'd2);
    step();
    step();
    check_all("run4", 32'h10, 32'hC0DE_000C, 32'h10, 1'b1, 32'd4);

    // Freeze three cycles with X on the data bus
    freeze = 1'b1;
    force_x = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("freeze", 32'h10, 32'hC0DE_000C, 32'h10, 1'b1, 32'd4);
    end
    freeze = 1'b0;
    force_x = 1'b0;
    step();
    check_all("unfreeze", 32'h14, 32'hC0DE_0010, 32'h14, 1'b1, 32'd5);

    // Branch overrides freeze, unaligned target, X on data bus
    branch_taken = 1'b1;
    branch_address = 32'h6B;
    freeze = 1'b1;
    force_x = 1'b1;
    step();
    check_all("branch", 32'h68, 32'h0, 32'h0, 1'b0, 32'd5);
    branch_taken = 1'b0;
    freeze = 1'b0;
    force_x = 1'b0;
    step();
    check_all("post_branch", 32'h6C, 32'hC0DE_0068, 32'h6C, 1'b1, 32'd6);

    // Wrap at the top of memory
    branch_taken = 1'b1;
    branch_address = 32'hFC;
    step();
    check_all("to_fc", 32'hFC, 32'h0, 32'h0, 1'b0, 32'd6);
    branch_taken = 1'b0;
    step();
    check_all("wrap", 32'h0, 32'hC0DE_00FC, 32'h0, 1'b1, 32'd7);
    branch_taken = 1'b1;
    branch_address = 32'h104;
    step();
    check_all("br_104", 32'h4, 32'h0, 32'h0, 1'b0, 32'd7);

    // Branch to the current pc refetches the same word
    branch_address = 32'h4;
    step();
    check_all("br_self", 32'h4, 32'h0, 32'h0, 1'b0, 32'd7);
    branch_taken = 1'b0;
    step();
    check_all("refetch", 32'h8, 32'hE3A0_1A01, 32'h8, 1'b1, 32'd8);

    // Async reset mid-freeze after a branch
    branch_taken = 1'b1;
    branch_address = 32'h40;
    step();
    branch_taken = 1'b0;
    freeze = 1'b1;
    step();
    check_all("pre_rst", 32'h40, 32'h0, 32'h0, 1'b0, 32'd8);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    step();
    rst = 1'b0;
    freeze = 1'b0;
    step();
    check_all("after_rst", 32'h4, 32'hE3A0_0014, 32'h4, 1'b1, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
